systolic_array: RTL and testbench

//  Bit-Fusion style precision-configurable matrix-vector compute array. Each cycle it multiplies an

---
 rtl/systolic_array_if.sv | 23 ++
 rtl/systolic_array.sv | 64 ++++++
 tb/tb_systolic_array.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/systolic_array_if.sv
// Operand/result bundle between the operand buffers, the compute array and the writeback stage.
// The master drives operands and configuration; the slave (the array) returns the column partial sums.
interface systolic_array_if #(
  parameter int ARRAY_SIZE = 8
);
  logic [3:0]                        in_width;
  logic [3:0]                        weight_width;
  logic                              s_in;
  logic                              s_weight;
  logic [ARRAY_SIZE*ARRAY_SIZE*8-1:0] weights;
  logic [ARRAY_SIZE*8-1:0]           inputs;
  logic [ARRAY_SIZE*32-1:0]          psums;

  modport master (
    output in_width, weight_width, s_in, s_weight, weights, inputs,
    input  psums
  );

  modport slave (
    input  in_width, weight_width, s_in, s_weight, weights, inputs,
    output psums
  );
endinterface

// File: rtl/systolic_array.sv
// Precision-configurable matrix-vector array: one product per cell, per-column adder reduction,
// a single registered output stage (latency 1, a new vector every cycle).
module systolic_array #(
  parameter int ARRAY_SIZE = 8
) (
  input logic              clk,
  input logic              rst,
  systolic_array_if.slave  bus
);

  // Widths outside 1..8 fall back to full 8-bit lanes; bits above the width are discarded.
  function automatic logic [8:0] decode_op(input logic [7:0] lane, input logic [3:0] field,
                                           input logic sgn);
    logic [3:0] w;
    logic       ext;
    logic [8:0] v;
    v   = 9'd0;
    w   = ((field == 4'd0) || (field > 4'd8)) ? 4'd8 : field;
    ext = sgn ? lane[3'(w - 4'd1)] : 1'b0;
    for (int i = 0; i < 8; i++) begin
      v[i] = (4'(i) < w) ? lane[i] : ext;
    end
    v[8] = ext;
    return v;
  endfunction

  // 9x9 signed product carried in 18 bits, then sign-extended into the 32-bit sum.
  function automatic logic [31:0] mac_term(input logic [8:0] a, input logic [8:0] b);
    logic signed [17:0] ax;
    logic signed [17:0] bx;
    logic signed [17:0] p;
    ax = {{9{a[8]}}, a};
    bx = {{9{b[8]}}, b};
    p  = ax * bx;
    return {{14{p[17]}}, p};
  endfunction

  logic [ARRAY_SIZE-1:0][31:0] psum_s;
  logic [ARRAY_SIZE-1:0][31:0] psum_r;

  // Combinational PE grid and column reduction.
  always_comb begin
    psum_s = '0;
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      for (int r = 0; r < ARRAY_SIZE; r++) begin
        psum_s[c] = psum_s[c] + mac_term(
          decode_op(bus.inputs[8*r +: 8], bus.in_width, bus.s_in),
          decode_op(bus.weights[8*(r*ARRAY_SIZE+c) +: 8], bus.weight_width, bus.s_weight));
      end
    end
  end

  // Output register; reset wins over the freshly computed sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      psum_r <= '0;
    end else begin
      psum_r <= psum_s;
    end
  end

  assign bus.psums = psum_r;

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: hand-computed vectors plus an integer reference model
// for the back-to-back stream.
module tb_systolic_array;
  localparam int N = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  systolic_array_if #(.ARRAY_SIZE(N)) bus ();

  systolic_array #(.ARRAY_SIZE(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dec(input logic [7:0] lane, input logic [3:0] f, input logic sg);
    int w;
    int v;
    w = (f >= 4'd1 && f <= 4'd8) ? int'(f) : 8;
    v = int'(lane) & ((1 << w) - 1);
    if (sg && v >= (1 << (w - 1))) v = v - (1 << w);
    return v;
  endfunction

  function automatic logic [31:0] model_col(input int c);
    int s;
    s = 0;
    for (int r = 0; r < N; r++) begin
      s = s + dec(bus.inputs[8*r +: 8], bus.in_width, bus.s_in) *
              dec(bus.weights[8*(r*N+c) +: 8], bus.weight_width, bus.s_weight);
    end
    return 32'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] exp);
    for (int c = 0; c < N; c++) begin
      check($sformatf("%s_c%0d", tag, c), bus.psums[32*c +: 32], exp);
    end
  endtask

  task automatic set_cfg(input logic [3:0] iw, input logic [3:0] ww, input logic si, input logic sw);
    bus.in_width     = iw;
    bus.weight_width = ww;
    bus.s_in         = si;
    bus.s_weight     = sw;
  endtask

  task automatic randomize_ops();
    for (int k = 0; k < N*N/4; k++) bus.weights[32*k +: 32] = $urandom;
    for (int k = 0; k < N/4; k++) bus.inputs[32*k +: 32] = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_v [N];

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    set_cfg(4'd8, 4'd8, 1'b0, 1'b0);
    bus.weights = '0;
    bus.inputs  = '0;
    #1;

    // 1: reset holds psums at zero regardless of operands
    for (int i = 0; i < 30; i++) begin
      randomize_ops();
      set_cfg(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      tick();
      check($sformatf("reset_%0d", i), bus.psums[31:0] | bus.psums[63:32] | bus.psums[95:64] |
            bus.psums[127:96] | bus.psums[159:128] | bus.psums[191:160] | bus.psums[223:192] |
            bus.psums[255:224], 32'd0);
    end
    rst = 1'b0;

    // 2: identity weights, inputs r+1
    set_cfg(4'd8, 4'd8, 1'b0, 1'b0);
    bus.weights = '0;
    for (int r = 0; r < N; r++) begin
      bus.weights[8*(r*N+r) +: 8] = 8'd1;
      bus.inputs[8*r +: 8]        = 8'(r + 1);
    end
    tick();
    for (int c = 0; c < N; c++) check($sformatf("ident_c%0d", c), bus.psums[32*c +: 32], 32'(c + 1));

    // 3: full-scale unsigned
    bus.weights = '1;
    bus.inputs  = '1;
    tick();
    check_all("full", 32'd520200);

    // widths 0 and 15 decode as 8 bits
    set_cfg(4'd0, 4'd15, 1'b0, 1'b0);
    tick();
    check_all("w0_w15", 32'd520200);

    // 4: signed inputs x signed weights, then unsigned inputs
    for (int k = 0; k < N*N; k++) bus.weights[8*k +: 8] = 8'h02;
    set_cfg(4'd8, 4'd8, 1'b1, 1'b1);
    tick();
    check_all("signed", 32'hFFFF_FFF0);
    set_cfg(4'd8, 4'd8, 1'b0, 1'b1);
    tick();
    check_all("mixed", 32'd4080);

    // 5: precision masking
    bus.weights = '1;
    set_cfg(4'd1, 4'd2, 1'b0, 1'b0);
    tick();
    check_all("mask_u", 32'd24);
    set_cfg(4'd1, 4'd2, 1'b1, 1'b1);
    tick();
    check_all("mask_s", 32'd8);

    // 6: back-to-back stream, results one edge after presentation
    for (int i = 0; i < 10; i++) begin
      randomize_ops();
      set_cfg(4'($urandom_range(1, 8)), 4'($urandom_range(1, 8)), 1'($urandom), 1'($urandom));
      for (int c = 0; c < N; c++) exp_v[c] = model_col(c);
      tick();
      for (int c = 0; c < N; c++) check($sformatf("b2b%0d_c%0d", i, c), bus.psums[32*c +: 32], exp_v[c]);
    end

    // reset mid-stream clears that edge only
    randomize_ops();
    rst = 1'b1;
    tick();
    check_all("mid_rst", 32'd0);
    rst = 1'b0;
    randomize_ops();
    set_cfg(4'd8, 4'd8, 1'b1, 1'b0);
    for (int c = 0; c < N; c++) exp_v[c] = model_col(c);
    tick();
    for (int c = 0; c < N; c++) check($sformatf("post_rst_c%0d", c), bus.psums[32*c +: 32], exp_v[c]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
